// File: rtl/dt1_lsu.sv
// dt1_lsu: memory-stage load/store unit.
// Takes the decoder's store/load size encodings and turns each op into one
// word-aligned request on a req/gnt/rvalid data port. Store data is
// replicated across byte lanes. Load data is sign- or zero-extended.
// Misaligned or illegal ops are answered with an error and never reach
// memory. An access that waits too long for gnt or rvalid is aborted.
module dt1_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  MemWriteM,
  input  logic [2:0]  LoadSizeM,
  input  logic        is_load,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  // The counter only has to reach TIMEOUT-1. A zero TIMEOUT turns the abort off.
  localparam int            CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  localparam bit            TO_EN = (TIMEOUT > 0);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [1:0]    size_r;
  logic          sign_r;
  logic [1:0]    lo_r;
  logic          req_ready_r, stall_r;
  logic          mem_req_r, mem_we_r;
  logic [31:0]   mem_addr_r, mem_wdata_r;
  logic [3:0]    mem_be_r;
  logic          resp_valid_r, resp_err_r;
  logic [31:0]   resp_rdata_r;

  logic          is_store_s, op_s, sign_s, bad_size_s, misalign_s, err_s;
  logic [1:0]    size_s;
  logic          timeout_s;
  logic [CW-1:0] cnt_step_s;

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    calc_be = 4'b0001 << lo;
      SZ_H:    calc_be = lo[1] ? 4'b1100 : 4'b0011;
      default: calc_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_B:    calc_wdata = {4{wd[7:0]}};
      SZ_H:    calc_wdata = {2{wd[15:0]}};
      default: calc_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] lo, input logic [31:0] rd);
    logic [15:0] sh;
    sh = 16'(rd >> {lo, 3'b000});
    case (size)
      SZ_B:    extend_load = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
      SZ_H:    extend_load = sgn ? {{16{sh[15]}}, sh} : {16'd0, sh};
      default: extend_load = rd;
    endcase
  endfunction

  // Decode the incoming op: access size, signedness and the error conditions.
  always_comb begin
    is_store_s = (MemWriteM != 2'b00);
    op_s       = is_store_s | is_load;
    size_s     = SZ_W;
    sign_s     = 1'b0;
    bad_size_s = 1'b0;
    if (is_store_s) begin
      case (MemWriteM)
        2'b10:   size_s = SZ_H;
        2'b11:   size_s = SZ_B;
        default: size_s = SZ_W;
      endcase
    end else begin
      case (LoadSizeM)
        3'b000:  size_s = SZ_W;
        3'b001:  begin size_s = SZ_B; sign_s = 1'b1; end
        3'b010:  size_s = SZ_B;
        3'b011:  begin size_s = SZ_H; sign_s = 1'b1; end
        3'b100:  size_s = SZ_H;
        default: bad_size_s = is_load;
      endcase
    end
    case (size_s)
      SZ_H:    misalign_s = addr[0];
      SZ_W:    misalign_s = (addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
    err_s = (is_store_s & is_load) | bad_size_s | misalign_s;
  end

  // Timeout detection; the counter saturates so a gnt on the last allowed
  // cycle leaves WAIT exactly one cycle to see rvalid.
  always_comb begin
    timeout_s = TO_EN && (cnt_r == LIMIT);
    if (cnt_r == LIMIT) begin
      cnt_step_s = cnt_r;
    end else begin
      cnt_step_s = cnt_r + CW'(1);
    end
  end

  // Access FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      size_r       <= 2'b00;
      sign_r       <= 1'b0;
      lo_r         <= 2'b00;
      req_ready_r  <= 1'b1;
      stall_r      <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_be_r     <= 4'd0;
      mem_wdata_r  <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && op_s) begin
            size_r      <= size_s;
            sign_r      <= sign_s;
            lo_r        <= addr[1:0];
            mem_we_r    <= is_store_s;
            mem_addr_r  <= {addr[31:2], 2'b00};
            mem_be_r    <= calc_be(size_s, addr[1:0]);
            mem_wdata_r <= calc_wdata(size_s, wdata);
            req_ready_r <= 1'b0;
            stall_r     <= 1'b1;
            cnt_r       <= '0;
            if (err_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else begin
              state_r   <= ST_REQ;
              mem_req_r <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_r <= 1'b0;
            if (mem_we_r) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              cnt_r   <= cnt_step_s;
            end
          end else if (timeout_s) begin
            mem_req_r    <= 1'b0;
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_step_s;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= extend_load(size_r, sign_r, lo_r, mem_rdata);
          end else if (timeout_s) begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_step_s;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'd0;
          req_ready_r  <= 1'b1;
          stall_r      <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_req_r    <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
          resp_rdata_r <= 32'd0;
          req_ready_r  <= 1'b1;
          stall_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign stall      = stall_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_be     = mem_be_r;
  assign mem_wdata  = mem_wdata_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;

endmodule
